// File: rtl/sar_dac_capture_pkg.sv
// Shared constants for the SAR capture path: FSM state encoding and default sizing.
package sar_dac_capture_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] COMPARE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam int DEFAULT_PRECISION     = 12;
  localparam int DEFAULT_SETTLE_CYCLES = 8;

endpackage

// File: rtl/sar_settle_timer.sv
// Down-counting dwell timer: load a count, tick it toward zero, expired while it sits at zero.
module sar_settle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/sar_dac_capture.sv
// Successive-approximation capture: binary-searches the DAC code against an external comparator.
// Optional build macro SAR_COMP_SYNC_EN adds a 2-flop synchroniser on compIn and lengthens each dwell by 2.
module sar_dac_capture
  import sar_dac_capture_pkg::*;
#(
  parameter int PRECISION     = DEFAULT_PRECISION,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 compIn,
  output logic [PRECISION-1:0] dacVal,
  output logic [PRECISION-1:0] result,
  output logic                 busy,
  output logic                 done
);

`ifdef SAR_COMP_SYNC_EN
  localparam int DWELL = SETTLE_CYCLES + 2;
`else
  localparam int DWELL = SETTLE_CYCLES;
`endif

  localparam int IW = $clog2(PRECISION);
  localparam int CW = $clog2(DWELL) + 1;
  localparam logic [CW-1:0]        RELOAD   = CW'(DWELL - 1);
  localparam logic [IW-1:0]        TOP_IDX  = IW'(PRECISION - 1);
  localparam logic [PRECISION-1:0] MSB_ONLY = {1'b1, {(PRECISION-1){1'b0}}};

  logic [1:0]           state;
  logic [IW-1:0]        bit_idx;
  logic                 comp_used;
  logic                 timer_load;
  logic                 timer_expired;
  logic [PRECISION-1:0] trial;

`ifdef SAR_COMP_SYNC_EN
  logic [1:0] comp_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      comp_sync <= 2'b00;
    end else begin
      comp_sync <= {comp_sync[0], compIn};
    end
  end

  assign comp_used = comp_sync[1];
`else
  assign comp_used = compIn;
`endif

  // Resolve the bit under test and arm the next lower bit in one step.
  always_comb begin
    trial = dacVal;
    trial[bit_idx] = comp_used;
    if (bit_idx != '0) begin
      trial[bit_idx - IW'(1)] = 1'b1;
    end
  end

  assign timer_load = ((state == IDLE) && start) ||
                      ((state == COMPARE) && (bit_idx != '0));

  sar_settle_timer #(
    .WIDTH(CW)
  ) u_settle_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(RELOAD),
    .tick      (state == SETTLE),
    .expired   (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      dacVal  <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_idx <= TOP_IDX;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dacVal  <= MSB_ONLY;
            bit_idx <= TOP_IDX;
            busy    <= 1'b1;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer_expired) begin
            state <= COMPARE;
          end
        end
        COMPARE: begin
          dacVal <= trial;
          if (bit_idx != '0) begin
            bit_idx <= bit_idx - IW'(1);
            state   <= SETTLE;
          end else begin
            result <= trial;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          done   <= 1'b0;
          dacVal <= result;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_dac_capture.sv
// Directed bench for sar_dac_capture: default 12-bit instance plus a 4-bit, 1-cycle-settle instance.
module tb_sar_dac_capture;

`ifdef SAR_COMP_SYNC_EN
  localparam int PER_BIT   = 8 + 3;
  localparam int PER_BIT_B = 1 + 3;
`else
  localparam int PER_BIT   = 8 + 1;
  localparam int PER_BIT_B = 1 + 1;
`endif
  localparam int LAT   = 12 * PER_BIT;
  localparam int LAT_B = 4 * PER_BIT_B;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        compIn;
  logic [11:0] dacVal;
  logic [11:0] result;
  logic        busy;
  logic        done;
  logic [11:0] analog;
  int          comp_mode;

  logic        start_b;
  logic        comp_b;
  logic [3:0]  dacVal_b;
  logic [3:0]  result_b;
  logic        busy_b;
  logic        done_b;

  int errors = 0;
  int checks = 0;
  int done_count = 0;

  always #5 clk = ~clk;

  // Ideal comparator, or tied high/low depending on comp_mode.
  assign compIn = (comp_mode == 0) ? (analog >= dacVal) : (comp_mode == 1);

  sar_dac_capture dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .compIn(compIn),
    .dacVal(dacVal),
    .result(result),
    .busy  (busy),
    .done  (done)
  );

  sar_dac_capture #(
    .PRECISION    (4),
    .SETTLE_CYCLES(1)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .start (start_b),
    .compIn(comp_b),
    .dacVal(dacVal_b),
    .result(result_b),
    .busy  (busy_b),
    .done  (done_b)
  );

  always @(negedge clk) begin
    if (done) done_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // One conversion on the 12-bit instance; snapshots the code after the first three compares.
  task automatic applyStimulus(input string tag, input logic [11:0] value, input int mode,
                               input logic [11:0] expected,
                               output logic [11:0] s1, output logic [11:0] s2, output logic [11:0] s3);
    int n;
    int done_at;
    int busy_cycles;
    int dc0;
    analog    = value;
    comp_mode = mode;
    dc0       = done_count;
    s1 = '0; s2 = '0; s3 = '0;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    checkOutput({tag, " msb"}, dacVal, 32'h800);
    n = 0;
    done_at = -1;
    busy_cycles = 0;
    while ((n <= LAT + 20) && (done_at < 0)) begin
      if (busy) busy_cycles++;
      stepCycle();
      n++;
      if (n == PER_BIT)     s1 = dacVal;
      if (n == 2 * PER_BIT) s2 = dacVal;
      if (n == 3 * PER_BIT) s3 = dacVal;
      if (done) done_at = n;
    end
    checkOutput({tag, " latency"}, done_at, LAT);
    checkOutput({tag, " result"}, result, expected);
    checkOutput({tag, " busy_cycles"}, busy_cycles, LAT);
    stepCycle();
    checkOutput({tag, " done_pulse"}, done, 1'b0);
    checkOutput({tag, " idle_dac"}, dacVal, expected);
    checkOutput({tag, " done_count"}, done_count - dc0, 1);
  endtask

  initial begin
    logic [11:0] s1, s2, s3;
    int n;
    int first;
    int second;
    int dc0;
    int done_at;

    reset = 1'b1; start = 1'b0; start_b = 1'b0; comp_b = 1'b0;
    comp_mode = 0; analog = '0;
    stepCycle();
    stepCycle();
    checkOutput("rst dacVal", dacVal, 0);
    checkOutput("rst result", result, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst done", done, 0);
    checkOutput("rst dacVal_b", dacVal_b, 0);
    reset = 1'b0;
    stepCycle();

    applyStimulus("a5c", 12'hA5C, 0, 12'hA5C, s1, s2, s3);
    checkOutput("a5c seq1", s1, 32'hC00);
    checkOutput("a5c seq2", s2, 32'hA00);
    checkOutput("a5c seq3", s3, 32'hB00);

    applyStimulus("tied1", 12'h000, 1, 12'hFFF, s1, s2, s3);
    applyStimulus("tied0", 12'h000, 2, 12'h000, s1, s2, s3);

    // start held high: back-to-back conversions two cycles apart.
    comp_mode = 1;
    start = 1'b1;
    stepCycle();
    n = 0; first = -1; second = -1;
    while (n < 3 * LAT) begin
      stepCycle();
      n++;
      if (done) begin
        if (first < 0) first = n;
        else begin
          second = n;
          break;
        end
      end
    end
    start = 1'b0;
    checkOutput("held first_done", first, LAT);
    checkOutput("held second_done", second, 2 * LAT + 2);
    stepCycle();
    stepCycle();
    checkOutput("held stops", busy, 0);

    // Extra start pulses while busy are ignored.
    comp_mode = 0;
    analog = 12'h3C3;
    dc0 = done_count;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    for (int i = 1; i <= LAT + 4; i++) begin
      start = (i == 20) || (i == 60);
      stepCycle();
    end
    start = 1'b0;
    checkOutput("extra done_count", done_count - dc0, 1);
    checkOutput("extra result", result, 32'h3C3);
    checkOutput("extra idle", busy, 0);

    // Reset in the middle of a conversion.
    analog = 12'h3FF;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    repeat (49) stepCycle();
    reset = 1'b1;
    stepCycle();
    checkOutput("midrst dacVal", dacVal, 0);
    checkOutput("midrst result", result, 0);
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst done", done, 0);
    reset = 1'b0;
    dc0 = done_count;
    repeat (LAT + 5) stepCycle();
    checkOutput("midrst no_done", done_count - dc0, 0);
    checkOutput("midrst idle_dac", dacVal, 0);
    applyStimulus("3ff", 12'h3FF, 0, 12'h3FF, s1, s2, s3);

    // Small instance: comparator noise outside COMPARE must not matter.
    start_b = 1'b1;
    stepCycle();
    start_b = 1'b0;
    n = 0;
    done_at = -1;
    while ((n < 40) && (done_at < 0)) begin
`ifdef SAR_COMP_SYNC_EN
      comp_b = (4'h9 >= dacVal_b);
`else
      if (((n + 1) % PER_BIT_B) == 0) comp_b = (4'h9 >= dacVal_b);
      else comp_b = 1'($urandom_range(0, 1));
`endif
      stepCycle();
      n++;
      if (done_b) done_at = n;
    end
    checkOutput("small latency", done_at, LAT_B);
    checkOutput("small result", result_b, 32'h9);
    stepCycle();
    checkOutput("small idle_dac", dacVal_b, 32'h9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sar_dac_capture.md
Name: sar_dac_capture

Overview:
- Successive-approximation capture controller. It is the read-back side of the DAC path: it drives the DAC code and reads an external analog comparator (analog input >= DAC output).
- It binary-searches the DAC code to digitise an external voltage, producing a PRECISION-bit result.
- It sits beside the DAC generator at the board top level. The result is mirrored to the LEDs by the top level.

Parameters:
- PRECISION, 12, DAC/result width in bits; minimum 2.
- SETTLE_CYCLES, 8, clk cycles the DAC/comparator settles after each code change before compIn is sampled; minimum 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset (OR of debounced pushbutton and pin resets).
- start  input  1  conversion request; level sampled only in IDLE.
- compIn  input  1  comparator output; 1 = analog input >= current DAC code.
- dacVal  output  PRECISION  code driven to the DAC.
- result  output  PRECISION  last completed conversion.
- busy  output  1  high from the cycle after start is accepted until DONE is entered.
- done  output  1  one-cycle pulse when result updates.

Behaviour:
- Reset values (reset high at a rising edge): dacVal=0, result=0, busy=0, done=0, state=IDLE, bit index=PRECISION-1, settle counter=0. Reset overrides every other input, including mid-conversion: the conversion is aborted and no done pulse is issued.
- States: IDLE, SETTLE, COMPARE, DONE.
- IDLE:
  - dacVal holds the last result.
  - If start=1: dacVal <= 1<<(PRECISION-1), bit index <= PRECISION-1, counter <= SETTLE_CYCLES-1, busy <= 1, go to SETTLE.
- SETTLE: decrement the counter; when counter==0, go to COMPARE. Dwell is SETTLE_CYCLES cycles.
- COMPARE (1 cycle), current bit index i:
  - If compIn=0, clear bit i of dacVal; otherwise keep it.
  - If i>0: set bit i-1, i <= i-1, reload the counter, go to SETTLE.
  - If i==0: result <= final code, done <= 1, busy <= 0, go to DONE.
- DONE (1 cycle): done <= 0, dacVal <= result, go to IDLE. start is ignored in DONE.
- Latency: with start accepted at edge E0, done is high in the cycle after edge E0 + PRECISION*(SETTLE_CYCLES+1).
  - Defaults: done high after edge E0+108; the next start can be accepted at edge E0+110.
- start while busy or in DONE has no effect and is not queued.
- compIn is sampled only in COMPARE; its value in all other states is don't-care.
- Arithmetic: bit set/clear only, no adders. The counter width is clog2(SETTLE_CYCLES)+1. result never exceeds 2^PRECISION-1.

Optional Feature:
- Macro: SAR_COMP_SYNC_EN.
- Defined:
  - compIn passes through a 2-flop synchroniser before use.
  - The SETTLE dwell per bit becomes SETTLE_CYCLES+2, so the synchronised sample reflects the settled code.
  - Latency becomes PRECISION*(SETTLE_CYCLES+3) (defaults: 132).
  - The synchroniser flops reset to 0.
- Undefined: compIn is used directly with the timing above. compIn must then be synchronous to clk.

Decomposition:
- Shared include/package holds:
  - state encoding localparams (IDLE=2'd0, SETTLE=2'd1, COMPARE=2'd2, DONE=2'd3);
  - default PRECISION=12;
  - the default SETTLE_CYCLES value.
- One natural sub-module: sar_settle_timer.
  - Ports: load, load value, tick, expired.
  - Reused by any future DAC dwell/ramp timing.
- The FSM and SAR register stay in sar_dac_capture.

Test Plan:
- Comparator model with analog input 0xA5C (compIn = input >= dacVal), start pulse → dacVal sequence begins 0x800, 0xC00, 0xA00, 0xB00, ...; result=0xA5C; done single pulse at E0+108; busy high for 108 cycles.
- compIn tied 1 → result=0xFFF; compIn tied 0 → result=0x000. After DONE, dacVal equals result in IDLE.
- start held high continuously → back-to-back conversions with exactly one idle cycle (DONE) plus one IDLE acceptance cycle between them; extra start pulses while busy produce no extra done.
- reset asserted at cycle 50 of a conversion → next cycle dacVal=0, result=0, busy=0, done=0, state IDLE; no done pulse; a new start afterwards converts 0x3FF correctly.
- SETTLE_CYCLES=1, PRECISION=4, input 0x9 → result=0x9, done at E0+8; compIn toggled randomly outside COMPARE has no effect on result.
- SAR_COMP_SYNC_EN defined, input 0x123 → result=0x123, done at E0+132.
